// File: rtl/lb_serial_pkg.sv
// Shared types and command bytes for the byte-stream LocalBus master.
package lb_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WR,
    RD,
    RD_WAIT,
    TX
  } state_t;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

endpackage

// File: rtl/lb_serial_tx_ser.sv
// 32-bit word to 4-byte MSB-first serializer with valid/ready handshake.
// done is a combinational pulse on the accept of the 4th byte.
module lb_serial_tx_ser (
  input  logic        clk_lb,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        tx_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  output logic        done
);

  logic [23:0] shreg;
  logic [1:0]  cnt;

  assign done = tx_valid && tx_ready && (cnt == 2'd3);

  // Load a word, then shift one byte out per accepted handshake
  always_ff @(posedge clk_lb or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      cnt      <= '0;
      tx_byte  <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      tx_byte  <= load_data[31:24];
      shreg    <= load_data[23:0];
      cnt      <= '0;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      cnt <= cnt + 2'd1;
      if (cnt == 2'd3) begin
        tx_valid <= 1'b0;
      end else begin
        tx_byte <= shreg[23:16];
        shreg   <= {shreg[15:0], 8'h00};
      end
    end
  end

endmodule

// File: rtl/lb_serial_master.sv
// Byte-stream to LocalBus master: parses 'W'/'R' commands from a receive
// byte stream, issues single-cycle lb_wr/lb_rd strobes and returns read data
// as four bytes. Optional read timeout enabled by LB_SERIAL_TIMEOUT_EN.
module lb_serial_master
  import lb_serial_pkg::*;
#(
  parameter int unsigned timeout_cycles = 1024,
  parameter logic [31:0] timeout_data   = 32'hDEADBEEF
) (
  input  logic        clk_lb,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_addr,
  output logic [31:0] lb_wr_d,
  input  logic [31:0] lb_rd_d,
  input  logic        lb_rd_rdy,
  output logic        rx_drop
);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic        is_rd;
  logic        tmo_hit;
  logic        ser_load;
  logic        ser_done;
  logic [31:0] ser_data;

`ifdef LB_SERIAL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] tmo_cnt;

  // Wait counter, held at zero outside RD_WAIT so each entry starts fresh
  always_ff @(posedge clk_lb or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != RD_WAIT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Hit on the cycle whose increment would reach timeout_cycles
  assign tmo_hit = (state == RD_WAIT) && (tmo_cnt == TW'(timeout_cycles - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^(32'(timeout_cycles));
  assign tmo_hit = 1'b0;
`endif

  // Real read data takes priority over a simultaneous timeout
  assign ser_load = (state == RD_WAIT) && (lb_rd_rdy || tmo_hit);
  assign ser_data = lb_rd_rdy ? lb_rd_d : timeout_data;

  // Command parser and bus strobe generation
  always_ff @(posedge clk_lb or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      is_rd    <= 1'b0;
      lb_addr  <= '0;
      lb_wr_d  <= '0;
      lb_wr    <= 1'b0;
      lb_rd    <= 1'b0;
      rx_drop  <= 1'b0;
    end else begin
      lb_wr   <= 1'b0;
      lb_rd   <= 1'b0;
      rx_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && (rx_byte == CMD_WR)) begin
            is_rd    <= 1'b0;
            byte_cnt <= '0;
            state    <= ADDR;
          end else if (rx_valid && (rx_byte == CMD_RD)) begin
            is_rd    <= 1'b1;
            byte_cnt <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (rx_valid) begin
            lb_addr  <= {lb_addr[23:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_rd) begin
                lb_rd <= 1'b1;
                state <= RD;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (rx_valid) begin
            lb_wr_d  <= {lb_wr_d[23:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              lb_wr <= 1'b1;
              state <= WR;
            end
          end
        end
        WR: begin
          rx_drop <= rx_valid;
          state   <= IDLE;
        end
        RD: begin
          rx_drop <= rx_valid;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          rx_drop <= rx_valid;
          if (ser_load) state <= TX;
        end
        TX: begin
          rx_drop <= rx_valid;
          if (ser_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  lb_serial_tx_ser u_tx_ser (
    .clk_lb    (clk_lb),
    .reset     (reset),
    .load      (ser_load),
    .load_data (ser_data),
    .tx_ready  (tx_ready),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .done      (ser_done)
  );

endmodule

// File: doc/lb_serial_master.md
# lb_serial_master

Byte-stream-to-LocalBus master that sits directly upstream of the SUMP2 core wrapper. It parses write and read commands from a UART receive byte stream into single-cycle `lb_wr`/`lb_rd` strobes with 32-bit address and data. It captures read data on `lb_rd_rdy` and returns it as four bytes through a transmit byte handshake. It runs entirely in the `clk_lb` domain.

## Interface
Parameters:
- `timeout_cycles`, default 1024: maximum `clk_lb` cycles to wait for `lb_rd_rdy` (used only with `LB_SERIAL_TIMEOUT_EN`).
- `timeout_data`, default 32'hDEADBEEF: word returned when a read times out.

Ports:
- `clk_lb` in 1: LocalBus clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `rx_byte` in 8: received byte.
- `rx_valid` in 1: one-cycle qualifier for `rx_byte`.
- `tx_byte` out 8: byte to transmit.
- `tx_valid` out 1: `tx_byte` is valid; held until accepted.
- `tx_ready` in 1: transmitter accepts the byte when `tx_valid && tx_ready`.
- `lb_wr` out 1: one-cycle write strobe.
- `lb_rd` out 1: one-cycle read strobe.
- `lb_addr` out 32: bus address; stable from strobe until command completion.
- `lb_wr_d` out 32: write data; stable with `lb_addr`.
- `lb_rd_d` in 32: read data; valid when `lb_rd_rdy` is high.
- `lb_rd_rdy` in 1: read data valid strobe.
- `rx_drop` out 1: one-cycle pulse when a received byte is discarded.

## Operation
- Command format: bytes are big-endian, MSB first.
  - Write: 0x57 ('W'), A3, A2, A1, A0, D3, D2, D1, D0.
  - Read: 0x52 ('R'), A3, A2, A1, A0.
- States:
  - IDLE: 0x57 → ADDR with write flag; 0x52 → ADDR with read flag; any other byte is ignored silently (no `rx_drop`).
  - ADDR: shift 4 bytes into `lb_addr`. After the 4th byte: write → DATA, read → RD.
  - DATA: shift 4 bytes into `lb_wr_d`. After the 4th byte → WR.
  - WR: `lb_wr`=1 for exactly one cycle, then → IDLE.
  - RD: `lb_rd`=1 for exactly one cycle, then → RD_WAIT.
  - RD_WAIT: on `lb_rd_rdy`=1, capture `lb_rd_d` into the tx shift register and → TX.
  - TX: present 4 bytes MSB first. Advance on each `tx_valid && tx_ready`. After the 4th accept → IDLE.
- A byte with `rx_valid`=1 in WR, RD, RD_WAIT or TX is discarded and pulses `rx_drop` in the following cycle.
- `lb_rd_rdy` outside RD_WAIT is ignored.
- A partial command has no inactivity timeout; it waits indefinitely for the remaining bytes.

## Timing
- Reset values (asynchronous):
  - state = IDLE.
  - `lb_wr`, `lb_rd`, `tx_valid`, `rx_drop` = 0.
  - `lb_addr`, `lb_wr_d` = 0.
  - `tx_byte` = 0; byte counter = 0.
- Write latency: `lb_wr` asserts the cycle after the cycle in which D0 is accepted (`rx_valid`).
- Read latency: `lb_rd` asserts the cycle after A0 is accepted.
- `lb_rd_rdy` is sampled from the cycle after `lb_rd`. A `lb_rd_rdy` coincident with `lb_rd` is ignored.
- `tx_valid` rises the cycle after `lb_rd_rdy` is captured.
- After each accept, the next byte is presented the following cycle. Back-to-back `tx_ready`=1 gives 4 bytes in 4 cycles.
- `tx_byte` must not change while `tx_valid`=1 and `tx_ready`=0.
- Minimum command spacing: IDLE accepts a new command byte the cycle after WR, or the cycle after the final TX accept.
- Byte counter is 2 bits and wraps 3→0 on each phase transition.
- Reset asserted mid-command aborts it. No strobe is emitted and any pending tx bytes are lost.

## Configuration
- `LB_SERIAL_TIMEOUT_EN` defined:
  - RD_WAIT runs a counter of width `$clog2(timeout_cycles+1)`, cleared on entry.
  - When the count reaches `timeout_cycles` without `lb_rd_rdy`, load `timeout_data` and → TX.
  - If `lb_rd_rdy` arrives in that same cycle, real data wins.
- Not defined: no counter is present; RD_WAIT waits indefinitely.

## Structure
- Package `lb_serial_pkg` holds:
  - state enum (IDLE, ADDR, DATA, WR, RD, RD_WAIT, TX);
  - command constants `CMD_WR`=8'h57 and `CMD_RD`=8'h52.
- Sub-module `lb_serial_tx_ser` is the natural split: a 32-bit load, 4-byte MSB-first serializer with valid/ready and a done pulse.
- The parser FSM stays in the top module.

## Test plan
- Write: bytes 57 00 00 00 04 12 34 56 78 → one `lb_wr` pulse with `lb_addr`=0x00000004 and `lb_wr_d`=0x12345678; no tx bytes.
- Read: 52 00 00 00 00 with responder returning `lb_rd_rdy` 3 cycles after `lb_rd` and data 0xCAFEF00D → tx bytes CA FE F0 0D in order.
- Tx backpressure: during the read above, `tx_ready` toggles 1/0 each cycle → 4 bytes are transmitted, each held stable while not ready.
- Garbage and drop:
  - bytes 00 FF 41 in IDLE → no strobes and no `rx_drop`;
  - a byte sent during RD_WAIT → `rx_drop` pulse and no state change.
- Timeout (macro on, `timeout_cycles`=16): read with no `lb_rd_rdy` → tx bytes DE AD BE EF starting 17 cycles after `lb_rd`.
- Reset mid-command: assert `reset` after 57 00 00 → all outputs return to 0. A following full write sequence then executes correctly.
